matvec_scheduler: RTL and testbench
===================================

MATVEC_SCHEDULER -- requirements
Module: matvec_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one matvec engine.
REQ-002 SHALL have parameters MAX_ROWS 64, MAX_COLS 64, BANDWIDTH 16 and DATA_WIDTH 16, matching the engine.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit (see REQ-024).
REQ-004 SHALL have one clock `clk` and an asynchronous, active-low reset `rst_n`, exactly as already decided.
REQ-005 SHALL have these requester-side ports:
- `req`  in  NUM_REQ  level request, one bit per requester.
- `req_num_rows`  in  NUM_REQ*($clog2(MAX_ROWS)+1)  packed per-requester row count.
- `req_num_cols`  in  NUM_REQ*($clog2(MAX_COLS)+1)  packed per-requester column count.
- `grant`  out  NUM_REQ  one-hot, held for the whole job.
- `vec_addr`  out  $clog2(MAX_COLS)  base column of the chunk being fetched.
- `vec_data`  in  DATA_WIDTH*BANDWIDTH  same-cycle chunk data from the granted requester.
REQ-006 SHALL have these engine-side ports:
- `mv_start`  out  1.
- `mv_num_rows`  out  $clog2(MAX_ROWS)+1.
- `mv_num_cols`  out  $clog2(MAX_COLS)+1.
- `mv_vector_write_enable`  out  1.
- `mv_vector_base_addr`  out  $clog2(MAX_COLS).
- `mv_vector_in`  out  DATA_WIDTH*BANDWIDTH.
- `mv_result_out`  in  2*DATA_WIDTH.
- `mv_result_valid`  in  1.
- `mv_busy`  in  1.
REQ-007 SHALL have these result-side ports:
- `res_data`  out  2*DATA_WIDTH.
- `res_valid`  out  1.
- `res_row`  out  $clog2(MAX_ROWS)  row index of `res_data`.
- `res_id`  out  $clog2(NUM_REQ)  owner of the result.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  qualifies `done`.

Function
REQ-008 SHALL implement the FSM states IDLE, LOAD, RUN, DRAIN and FIN.
REQ-009 In IDLE with any `req` set, SHALL grant round-robin, starting the search one past the last granted index (index 0 first after reset), and latch that requester's rows and columns.
REQ-010 SHALL reject a job with rows==0, cols==0, rows>MAX_ROWS or cols>MAX_COLS: go directly to FIN with `err`=1 and never assert `mv_start`.
REQ-011 In LOAD, SHALL fetch ceil(cols/BANDWIDTH) chunks, one per cycle, with `vec_addr` = 0, BANDWIDTH, 2*BANDWIDTH, ...
REQ-012 SHALL drive `mv_vector_write_enable`=1, `mv_vector_base_addr`=`vec_addr` and `mv_vector_in`=`vec_data` combinationally in each LOAD cycle.
REQ-013 SHALL pulse `mv_start` for exactly one cycle, coincident with the first chunk write, and never while `mv_busy`=1.
REQ-014 SHALL move LOAD->RUN in the cycle after the last chunk; for cols<=BANDWIDTH, LOAD lasts one cycle.
REQ-015 SHALL hold `mv_num_rows` and `mv_num_cols` stable at the latched values from LOAD entry until DRAIN exit.
REQ-016 In RUN, each `mv_result_valid` SHALL produce `res_valid`=1 one cycle later, with registered `res_data`, `res_row` (0,1,2,...) and `res_id` = granted index.
REQ-017 SHALL ignore `mv_result_valid` outside RUN.
REQ-018 SHALL leave RUN for DRAIN once the row count reaches the latched rows.
REQ-019 SHALL leave DRAIN for FIN when `mv_busy`=0.
REQ-020 In FIN (one cycle), SHALL pulse `done` with `err`, then drop `grant` and return to IDLE; a new grant is possible the following cycle.
REQ-021 SHALL keep `grant` stable while `req` is deasserted mid-job; the job runs to completion.

Reset
REQ-022 While `rst_n`=0, SHALL force IDLE, `grant`=0, all strobes=0, `res_data`=0, `res_row`=0, `res_id`=0, `err`=0 and the round-robin pointer=0.
REQ-023 Reset mid-job SHALL abandon the job with no `done`; the engine shares the same reset.

Configuration
REQ-024 With MATVEC_SCHED_TIMEOUT_EN defined, SHALL count RUN/DRAIN cycles since the last `mv_result_valid` or state entry; at TIMEOUT_CYCLES it SHALL go to FIN with `err`=1.
REQ-025 Without MATVEC_SCHED_TIMEOUT_EN, SHALL have no watchdog counter and never time out.

Structure
REQ-026 SHALL take the FSM state enum and the default parameter values from shared package matvec_pkg.
REQ-027 SHALL place the round-robin arbiter in sub-module rr_arbiter (request vector, pointer update, one-hot grant).

Verification
REQ-028 Single requester: req[2]=1, rows=4, cols=16 -> grant=0100; one chunk at addr 0; mv_start once; 4 res_valid with res_row 0..3 and res_id=2; done=1, err=0.
REQ-029 Multi-chunk load: cols=40, BANDWIDTH=16 -> vec_addr 0,16,32 on consecutive cycles; mv_start with addr 0 only.
REQ-030 Fairness: req=1111 held for 8 jobs -> grant sequence 0,1,2,3,0,1,2,3.
REQ-031 Bad config: rows=0 -> no mv_start; done=1, err=1 within 2 cycles of grant.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=32): engine model never asserts mv_result_valid -> done=1, err=1 32 cycles into RUN; next request served.
REQ-033 Reset mid-RUN after 2 of 4 results -> all outputs at reset values, no done; a new request after reset is granted to index 0 first.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and default sizing for the matvec scheduler slice.
// The defaults here mirror the matvec engine the scheduler feeds.
package matvec_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_MAX_ROWS       = 64;
  localparam int DEF_MAX_COLS       = 64;
  localparam int DEF_BANDWIDTH      = 16;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    FIN
  } sched_state_t;

endpackage

// File: rtl/matvec_scheduler_if.sv
// Bundle of requester, engine and result signals around the matvec scheduler.
// The master modport is the scheduler itself; slave is everything around it.
interface matvec_scheduler_if
  import matvec_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_ROWS   = DEF_MAX_ROWS,
  parameter int MAX_COLS   = DEF_MAX_COLS,
  parameter int BANDWIDTH  = DEF_BANDWIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  localparam int RW  = $clog2(MAX_ROWS) + 1;
  localparam int CW  = $clog2(MAX_COLS) + 1;
  localparam int AW  = $clog2(MAX_COLS);
  localparam int RIW = $clog2(MAX_ROWS);
  localparam int IW  = $clog2(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*RW-1:0]           req_num_rows;
  logic [NUM_REQ*CW-1:0]           req_num_cols;
  logic [NUM_REQ-1:0]              grant;
  logic [AW-1:0]                   vec_addr;
  logic [DATA_WIDTH*BANDWIDTH-1:0] vec_data;

  // engine side
  logic                            mv_start;
  logic [RW-1:0]                   mv_num_rows;
  logic [CW-1:0]                   mv_num_cols;
  logic                            mv_vector_write_enable;
  logic [AW-1:0]                   mv_vector_base_addr;
  logic [DATA_WIDTH*BANDWIDTH-1:0] mv_vector_in;
  logic [2*DATA_WIDTH-1:0]         mv_result_out;
  logic                            mv_result_valid;
  logic                            mv_busy;

  // result side
  logic [2*DATA_WIDTH-1:0]         res_data;
  logic                            res_valid;
  logic [RIW-1:0]                  res_row;
  logic [IW-1:0]                   res_id;
  logic                            done;
  logic                            err;

  modport master (
    input  req, req_num_rows, req_num_cols, vec_data,
    input  mv_result_out, mv_result_valid, mv_busy,
    output grant, vec_addr,
    output mv_start, mv_num_rows, mv_num_cols, mv_vector_write_enable,
    output mv_vector_base_addr, mv_vector_in,
    output res_data, res_valid, res_row, res_id, done, err
  );

  modport slave (
    output req, req_num_rows, req_num_cols, vec_data,
    output mv_result_out, mv_result_valid, mv_busy,
    input  grant, vec_addr,
    input  mv_start, mv_num_rows, mv_num_cols, mv_vector_write_enable,
    input  mv_vector_base_addr, mv_vector_in,
    input  res_data, res_valid, res_row, res_id, done, err
  );

endinterface

// File: rtl/matvec_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the
// pointer, and moves the pointer one past the winner when told to.
module rr_arbiter
  import matvec_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  // Scan from the pointer upwards with wrap and take the first requester.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        found         = 1'b1;
      end
    end
  end

  // Next search starts one past the current winner.
  always_comb begin
    ptr_d = (idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + IW'(1);
  end

  // Pointer only moves when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i && (|req_i)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/matvec_scheduler.sv
// Shares one matvec engine among NUM_REQ requesters: arbitrates, streams the
// winner's vector into the engine, forwards results tagged with row and owner.
// Optional watchdog on RUN/DRAIN: define MATVEC_SCHED_TIMEOUT_EN.
module matvec_scheduler
  import matvec_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int MAX_ROWS       = DEF_MAX_ROWS,
  parameter int MAX_COLS       = DEF_MAX_COLS,
  parameter int BANDWIDTH      = DEF_BANDWIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  matvec_scheduler_if.master bus
);

  localparam int RW  = $clog2(MAX_ROWS) + 1;
  localparam int CW  = $clog2(MAX_COLS) + 1;
  localparam int AW  = $clog2(MAX_COLS);
  localparam int RIW = $clog2(MAX_ROWS);
  localparam int IW  = $clog2(NUM_REQ);

  sched_state_t            state_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [IW-1:0]           grantIdx_q;
  logic [RW-1:0]           rows_q;
  logic [CW-1:0]           cols_q;
  logic [CW-1:0]           addr_q;
  logic [RW-1:0]           rowCnt_q;
  logic [2*DATA_WIDTH-1:0] resData_q;
  logic                    resValid_q;
  logic [RIW-1:0]          resRow_q;
  logic [IW-1:0]           resId_q;
  logic                    done_q;
  logic                    err_q;

  logic [NUM_REQ-1:0]      arbGrant;
  logic [IW-1:0]           arbIdx;
  logic [RW-1:0]           selRows;
  logic [CW-1:0]           selCols;
  logic                    badCfg;
  logic [CW:0]             nextAddr;
  logic                    lastChunk;
  logic                    inLoad;
  logic                    loadStall;
  logic                    timeoutHit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.req),
    .advance_i(state_q == IDLE),
    .grant_o  (arbGrant),
    .idx_o    (arbIdx)
  );

  // Candidate job geometry and the per-chunk load bookkeeping.
  always_comb begin
    selRows   = bus.req_num_rows[arbIdx*RW +: RW];
    selCols   = bus.req_num_cols[arbIdx*CW +: CW];
    badCfg    = (selRows == '0) || (selCols == '0) ||
                (selRows > RW'(MAX_ROWS)) || (selCols > CW'(MAX_COLS));
    nextAddr  = {1'b0, addr_q} + (CW+1)'(BANDWIDTH);
    lastChunk = nextAddr >= {1'b0, cols_q};
    inLoad    = (state_q == LOAD);
    loadStall = (addr_q == '0) && bus.mv_busy;
  end

`ifdef MATVEC_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog_q;

  // Idle cycles spent waiting on the engine; a result or a new state restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (!(state_q == RUN || state_q == DRAIN) ||
                 (state_q == RUN && bus.mv_result_valid)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WW'(1);
    end
  end

  assign timeoutHit = (state_q == RUN || state_q == DRAIN) &&
                      (wdog_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Main job FSM: arbitrate, load the vector, collect rows, wait for idle engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grantIdx_q <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      addr_q     <= '0;
      rowCnt_q   <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
      resRow_q   <= '0;
      resId_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resValid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q    <= arbGrant;
            grantIdx_q <= arbIdx;
            rows_q     <= selRows;
            cols_q     <= selCols;
            addr_q     <= '0;
            rowCnt_q   <= '0;
            if (badCfg) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (!loadStall) begin
            if (lastChunk) begin
              state_q <= RUN;
            end else begin
              addr_q <= nextAddr[CW-1:0];
            end
          end
        end
        RUN: begin
          if (bus.mv_result_valid) begin
            resValid_q <= 1'b1;
            resData_q  <= bus.mv_result_out;
            resRow_q   <= rowCnt_q[RIW-1:0];
            resId_q    <= grantIdx_q;
            rowCnt_q   <= rowCnt_q + RW'(1);
            if (rowCnt_q + RW'(1) == rows_q) begin
              state_q <= DRAIN;
            end
          end else if (timeoutHit) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.mv_busy) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (timeoutHit) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          grant_q <= '0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant                  = grant_q;
  assign bus.vec_addr               = addr_q[AW-1:0];
  assign bus.mv_start               = inLoad && (addr_q == '0) && !bus.mv_busy;
  assign bus.mv_num_rows            = rows_q;
  assign bus.mv_num_cols            = cols_q;
  assign bus.mv_vector_write_enable = inLoad && !loadStall;
  assign bus.mv_vector_base_addr    = addr_q[AW-1:0];
  assign bus.mv_vector_in           = bus.vec_data;
  assign bus.res_data               = resData_q;
  assign bus.res_valid              = resValid_q;
  assign bus.res_row                = resRow_q;
  assign bus.res_id                 = resId_q;
  assign bus.done                   = done_q;
  assign bus.err                    = err_q;

endmodule

// File: tb/tb_matvec_scheduler.sv
// Directed bench for matvec_scheduler with a small behavioural engine model.
// Timeout scenario is built only when MATVEC_SCHED_TIMEOUT_EN is defined.
module tb_matvec_scheduler;

  localparam int NUM_REQ = 4;
  localparam int BW      = 16;
  localparam int DW      = 16;

  logic clk;
  logic rst_n;
  int   cyc;

  int checkCount;
  int passCount;

  matvec_scheduler_if #(
    .NUM_REQ(NUM_REQ), .MAX_ROWS(64), .MAX_COLS(64), .BANDWIDTH(BW), .DATA_WIDTH(DW)
  ) bus ();

  matvec_scheduler #(
    .NUM_REQ(NUM_REQ), .MAX_ROWS(64), .MAX_COLS(64), .BANDWIDTH(BW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Requester chunk data is a simple function of the requested address.
  assign bus.vec_data = {BW{16'h5A00 | {10'b0, bus.vec_addr}}};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Log of everything observed on the DUT outputs.
  logic [3:0]  grantSeq[$];
  int          grantCycle;
  logic [5:0]  weAddrs[$];
  int          weCycles[$];
  int          lastWeCycle;
  int          weBad;
  int          startCount;
  logic [5:0]  startAddr;
  logic [6:0]  startRows;
  logic [6:0]  startCols;
  logic [5:0]  resRows[$];
  logic [1:0]  resIds[$];
  logic [31:0] resData[$];
  int          doneCount;
  logic        doneErr;
  int          doneCycle;
  logic [3:0]  prevGrant;

  // Engine model state.
  logic [15:0] engTag;
  logic        engSilent;
  int          engState;
  int          engRow;
  int          engRows;
  int          engTail;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  task automatic clearLog();
    grantSeq.delete(); weAddrs.delete(); weCycles.delete();
    resRows.delete(); resIds.delete(); resData.delete();
    grantCycle = 0; lastWeCycle = 0; weBad = 0; startCount = 0;
    startAddr = '0; startRows = '0; startCols = '0;
    doneCount = 0; doneErr = 1'b0; doneCycle = 0;
  endtask

  task automatic setFields(input int rows, input int cols);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_num_rows[i*7 +: 7] = 7'(rows);
      bus.req_num_cols[i*7 +: 7] = 7'(cols);
    end
  endtask

  // Raise req, drop it as soon as the grant appears, then wait for done.
  task automatic applyStimulus(input logic [3:0] mask, input int rows, input int cols,
                               input int budget);
    int dones;
    dones = 0;
    setFields(rows, cols);
    bus.req = mask;
    for (int c = 0; c < budget && dones == 0; c++) begin
      @(negedge clk);
      if (bus.grant != '0) bus.req = '0;
      if (bus.done) dones++;
    end
    if (dones == 0) checkOutput("jobDoneTimeout", 32'(dones), 32'd1);
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: sample all DUT outputs on the falling edge.
  initial begin
    prevGrant = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevGrant = '0;
      end else begin
        if (bus.grant != '0 && prevGrant == '0) begin
          grantSeq.push_back(bus.grant);
          grantCycle = cyc;
        end
        prevGrant = bus.grant;
        if (bus.mv_vector_write_enable) begin
          weAddrs.push_back(bus.vec_addr);
          weCycles.push_back(cyc);
          lastWeCycle = cyc;
          if (bus.mv_vector_base_addr !== bus.vec_addr || bus.mv_vector_in !== bus.vec_data)
            weBad++;
        end
        if (bus.mv_start) begin
          startCount++;
          startAddr = bus.vec_addr;
          startRows = bus.mv_num_rows;
          startCols = bus.mv_num_cols;
        end
        if (bus.res_valid) begin
          resRows.push_back(bus.res_row);
          resIds.push_back(bus.res_id);
          resData.push_back(bus.res_data);
        end
        if (bus.done) begin
          doneCount++;
          doneErr   = bus.err;
          doneCycle = cyc;
        end
      end
    end
  end

  // Engine model: after mv_start, wait out the load, emit one row every other
  // cycle, stay busy two more cycles, then go idle.
  initial begin
    bus.mv_busy = 1'b0; bus.mv_result_valid = 1'b0; bus.mv_result_out = '0;
    engState = 0; engRow = 0; engRows = 0; engTail = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mv_busy = 1'b0; bus.mv_result_valid = 1'b0; engState = 0;
      end else begin
        case (engState)
          0: begin
            bus.mv_result_valid = 1'b0;
            if (bus.mv_start && !engSilent) begin
              engRows = int'(bus.mv_num_rows); engRow = 0; engState = 1;
            end
          end
          1: begin
            bus.mv_busy = 1'b1;
            if (!bus.mv_vector_write_enable) engState = 2;
          end
          2: begin
            if (engRow < engRows && !bus.mv_result_valid) begin
              bus.mv_result_valid = 1'b1;
              bus.mv_result_out   = {engTag, 16'(engRow)};
              engRow++;
            end else begin
              bus.mv_result_valid = 1'b0;
              if (engRow >= engRows) begin engState = 3; engTail = 2; end
            end
          end
          default: begin
            bus.mv_result_valid = 1'b0;
            engTail--;
            if (engTail <= 0) begin bus.mv_busy = 1'b0; engState = 0; end
          end
        endcase
      end
    end
  end

  initial begin
    logic [3:0] expFair[8];
    int n;
    int seen;
    expFair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    checkCount = 0; passCount = 0;
    engTag = 16'h0000; engSilent = 1'b0;
    rst_n = 1'b0;
    bus.req = '0;
    setFields(1, 16);
    clearLog();
    repeat (3) @(negedge clk);

    // Reset values.
    checkOutput("rstGrant", 32'(bus.grant), 32'h0);
    checkOutput("rstResValid", 32'(bus.res_valid), 32'h0);
    checkOutput("rstDone", 32'(bus.done), 32'h0);
    checkOutput("rstErr", 32'(bus.err), 32'h0);
    checkOutput("rstStart", 32'(bus.mv_start), 32'h0);
    checkOutput("rstWe", 32'(bus.mv_vector_write_enable), 32'h0);
    checkOutput("rstResData", bus.res_data, 32'h0);

    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four requesters held for eight short jobs.
    $display("[TB] fairness");
    clearLog(); engTag = 16'h00F0; setFields(1, 16);
    bus.req = 4'hF; n = 0;
    for (int c = 0; c < 2000 && n < 8; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n++;
        if (n == 8) bus.req = '0;
      end
    end
    checkOutput("fairJobs", 32'(n), 32'd8);
    repeat (2) @(negedge clk);
    checkOutput("fairGrantCount", 32'(grantSeq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < grantSeq.size())
        checkOutput($sformatf("fairGrant%0d", i), 32'(grantSeq[i]), 32'(expFair[i]));

    // Single requester 2, 4 rows, one chunk; req dropped right after grant.
    $display("[TB] single requester");
    clearLog(); engTag = 16'h1234;
    applyStimulus(4'b0100, 4, 16, 300);
    checkOutput("s1Grant", 32'(grantSeq[0]), 32'b0100);
    checkOutput("s1Chunks", 32'(weAddrs.size()), 32'd1);
    checkOutput("s1ChunkAddr", 32'(weAddrs[0]), 32'd0);
    checkOutput("s1Starts", 32'(startCount), 32'd1);
    checkOutput("s1NumRows", 32'(startRows), 32'd4);
    checkOutput("s1NumCols", 32'(startCols), 32'd16);
    checkOutput("s1ResCount", 32'(resRows.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("s1Row%0d", i), 32'(resRows[i]), 32'(i));
      checkOutput($sformatf("s1Id%0d", i), 32'(resIds[i]), 32'd2);
      checkOutput($sformatf("s1Data%0d", i), resData[i], {16'h1234, 16'(i)});
    end
    checkOutput("s1Done", 32'(doneCount), 32'd1);
    checkOutput("s1Err", 32'(doneErr), 32'd0);
    checkOutput("s1VecPath", 32'(weBad), 32'd0);

    // Multi-chunk load: 40 columns -> three chunks.
    $display("[TB] multi-chunk");
    clearLog(); engTag = 16'h4000;
    applyStimulus(4'b0001, 2, 40, 300);
    checkOutput("mcGrant", 32'(grantSeq[0]), 32'b0001);
    checkOutput("mcChunks", 32'(weAddrs.size()), 32'd3);
    checkOutput("mcAddr0", 32'(weAddrs[0]), 32'd0);
    checkOutput("mcAddr1", 32'(weAddrs[1]), 32'd16);
    checkOutput("mcAddr2", 32'(weAddrs[2]), 32'd32);
    checkOutput("mcGap01", 32'(weCycles[1] - weCycles[0]), 32'd1);
    checkOutput("mcGap12", 32'(weCycles[2] - weCycles[1]), 32'd1);
    checkOutput("mcStarts", 32'(startCount), 32'd1);
    checkOutput("mcStartAddr", 32'(startAddr), 32'd0);
    checkOutput("mcResCount", 32'(resRows.size()), 32'd2);
    checkOutput("mcData1", resData[1], {16'h4000, 16'd1});
    checkOutput("mcErr", 32'(doneErr), 32'd0);

    // Bad configurations: zero rows, then too many columns.
    $display("[TB] bad config");
    clearLog();
    applyStimulus(4'b0010, 0, 16, 50);
    checkOutput("bcGrant", 32'(grantSeq[0]), 32'b0010);
    checkOutput("bcStarts", 32'(startCount), 32'd0);
    checkOutput("bcWrites", 32'(weAddrs.size()), 32'd0);
    checkOutput("bcDone", 32'(doneCount), 32'd1);
    checkOutput("bcErr", 32'(doneErr), 32'd1);
    checkOutput("bcLatencyOk", 32'(doneCycle - grantCycle <= 2), 32'd1);
    clearLog();
    applyStimulus(4'b1000, 3, 65, 50);
    checkOutput("bc2Starts", 32'(startCount), 32'd0);
    checkOutput("bc2Err", 32'(doneErr), 32'd1);

    // Reset in the middle of RUN after two of four results.
    $display("[TB] reset mid-run");
    clearLog(); engTag = 16'h7700; setFields(4, 16);
    bus.req = 4'b0010; seen = 0;
    for (int c = 0; c < 300 && seen < 2; c++) begin
      @(negedge clk);
      if (bus.grant != '0) bus.req = '0;
      if (bus.res_valid) seen++;
    end
    checkOutput("mrSeenTwo", 32'(seen), 32'd2);
    rst_n = 1'b0; bus.req = '0;
    #1;
    checkOutput("mrGrant", 32'(bus.grant), 32'h0);
    checkOutput("mrResRow", 32'(bus.res_row), 32'h0);
    checkOutput("mrResId", 32'(bus.res_id), 32'h0);
    checkOutput("mrResData", bus.res_data, 32'h0);
    checkOutput("mrDoneErr", 32'({bus.done, bus.err, bus.res_valid, bus.mv_start}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("mrNoDone", 32'(doneCount), 32'd0);
    clearLog(); engTag = 16'h0101;
    applyStimulus(4'b1111, 2, 16, 300);
    checkOutput("mrFirstGrant", 32'(grantSeq[0]), 32'b0001);
    checkOutput("mrJobRes", 32'(resRows.size()), 32'd2);
    checkOutput("mrJobErr", 32'(doneErr), 32'd0);

`ifdef MATVEC_SCHED_TIMEOUT_EN
    // Silent engine: watchdog ends the job 32 cycles into RUN.
    $display("[TB] timeout");
    clearLog(); engSilent = 1'b1;
    applyStimulus(4'b0100, 4, 16, 300);
    checkOutput("toDone", 32'(doneCount), 32'd1);
    checkOutput("toErr", 32'(doneErr), 32'd1);
    checkOutput("toCycles", 32'(doneCycle - lastWeCycle), 32'd33);
    checkOutput("toNoRes", 32'(resRows.size()), 32'd0);
    clearLog(); engSilent = 1'b0; engTag = 16'h0E0E;
    applyStimulus(4'b0001, 1, 16, 300);
    checkOutput("toNextGrant", 32'(grantSeq[0]), 32'b0001);
    checkOutput("toNextRes", 32'(resRows.size()), 32'd1);
    checkOutput("toNextErr", 32'(doneErr), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
